// File: rtl/layer_scan_pkg.sv
// Shared types and sizing helpers for the layer RAM scan controller.
package layer_scan_pkg;

  // Scan sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LAT   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    GAP   = 3'd5
  } scan_state_t;

  // Default configuration
  localparam int unsigned DEF_PIXEL_NUM      = 32'd64;
  localparam int unsigned DEF_RD_LAT         = 32'd1;
  localparam int unsigned DEF_RST_CYCLES     = 32'd14000;
  localparam int unsigned DEF_REFRESH_CYCLES = 32'd2500000;

  // Address width for n pixels (at least one bit)
  function automatic int unsigned addr_w(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  // Width of a counter that must hold the value n
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n > 32'd0) begin
      return $clog2(n + 32'd1);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/scan_gap_timer.sv
// Loadable down-counter that measures a window of N cycles.
// Loading N starts the window on the next cycle; expire_out is high during the
// last window cycle. expire_nxt_out is the value expire_out takes next cycle,
// so a caller can register a pulse that lines up with that last cycle.
module scan_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         load_in,
  input  logic [W-1:0] load_val_in,
  input  logic         run_in,
  output logic         expire_out,
  output logic         expire_nxt_out
);

  localparam logic [W-1:0] ZERO = W'(32'd0);
  localparam logic [W-1:0] ONE  = W'(32'd1);

  // cnt_q holds the number of window cycles still to come after the current one
  logic [W-1:0] cnt_q, cnt_d;
  logic         exp_q, exp_d;

  // Next count: load has priority, otherwise count down while running
  always_comb begin
    cnt_d = cnt_q;
    exp_d = 1'b0;
    if (load_in) begin
      if (load_val_in == ZERO) begin
        cnt_d = ZERO;
      end else begin
        cnt_d = load_val_in - ONE;
      end
      exp_d = (cnt_d == ZERO);
    end else if (run_in && (cnt_q != ZERO)) begin
      cnt_d = cnt_q - ONE;
      exp_d = (cnt_d == ZERO);
    end else begin
      cnt_d = cnt_q;
      exp_d = 1'b0;
    end
  end

  // Counter and expire registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= ZERO;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expire_out     = exp_q;
  assign expire_nxt_out = exp_d;

endmodule

// File: rtl/layer_scan_ctl.sv
// Layer RAM readout sequencer feeding the eight LED-strip encoders.
// Per pixel: one RAM read, wait out the read latency, one start pulse to the
// encoders, then wait for their combined done. After the last pixel the strip
// latch gap is timed and frame_done_out pulses on its final cycle.
// Optional feature: define LAYER_SCAN_REFRESH_EN to replay the last frame after
// REFRESH_CYCLES idle cycles without a new frame_rdy_in.
module layer_scan_ctl
  import layer_scan_pkg::*;
#(
  parameter int unsigned PIXEL_NUM      = DEF_PIXEL_NUM,
  parameter int unsigned RD_LAT         = DEF_RD_LAT,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  localparam int unsigned ADDR_W        = addr_w(PIXEL_NUM)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_rdy_in,
  input  logic              pixel_done_in,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic              pixel_start_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              frame_drop_out
);

  // One timer serves both the latency hold and the latch gap
  localparam int unsigned TMR_MAX = (RST_CYCLES > RD_LAT) ? RST_CYCLES : RD_LAT;
  localparam int unsigned TMR_W   = cnt_w(TMR_MAX);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(32'd0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(32'd1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXEL_NUM - 32'd1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = TMR_W'(32'd0);
  localparam logic [TMR_W-1:0]  LAT_LOAD  = TMR_W'(RD_LAT - 32'd1);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'(RST_CYCLES);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pending_q, pending_d;
  logic              rd_en_q, rd_en_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;

  logic              tmr_load_s;
  logic [TMR_W-1:0]  tmr_val_s;
  logic              tmr_run_s;
  logic              tmr_exp_s;
  logic              tmr_exp_nxt_s;
  logic              refresh_go_s;

  assign tmr_run_s = (state_q == LAT) || (state_q == GAP);

  scan_gap_timer #(
    .W (TMR_W)
  ) u_gap_timer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_in        (tmr_load_s),
    .load_val_in    (tmr_val_s),
    .run_in         (tmr_run_s),
    .expire_out     (tmr_exp_s),
    .expire_nxt_out (tmr_exp_nxt_s)
  );

`ifdef LAYER_SCAN_REFRESH_EN
  localparam int unsigned      REF_W    = cnt_w(REFRESH_CYCLES);
  localparam logic [REF_W-1:0] REF_LOAD = REF_W'(REFRESH_CYCLES - 32'd1);

  logic ref_load_s;
  logic ref_run_s;
  logic ref_exp_s;
  logic ref_exp_nxt_s;
  logic has_frame_q, has_frame_d;

  // Window restarts each time the sequencer drops back into IDLE
  assign ref_load_s   = (state_q != IDLE) && (state_d == IDLE);
  assign ref_run_s    = (state_q == IDLE);
  assign refresh_go_s = ref_exp_s && has_frame_q;

  scan_gap_timer #(
    .W (REF_W)
  ) u_refresh_timer (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .load_in        (ref_load_s),
    .load_val_in    (REF_LOAD),
    .run_in         (ref_run_s),
    .expire_out     (ref_exp_s),
    .expire_nxt_out (ref_exp_nxt_s)
  );

  // A replay only makes sense once a complete frame has been shown
  always_comb begin
    if ((state_q == GAP) && tmr_exp_s) begin
      has_frame_d = 1'b1;
    end else begin
      has_frame_d = has_frame_q;
    end
  end

  // Frame-shown flag register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      has_frame_q <= 1'b0;
    end else begin
      has_frame_q <= has_frame_d;
    end
  end
`else
  assign refresh_go_s = 1'b0;
`endif

  // Next-state, address, pending-frame and registered-output decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = TMR_ZERO;

    case (state_q)
      IDLE: begin
        if (frame_rdy_in || pending_q || refresh_go_s) begin
          state_d = READ;
          addr_d  = ADDR_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // With single-cycle RAM latency the hold state is skipped entirely
        if (RD_LAT > 32'd1) begin
          state_d    = LAT;
          tmr_load_s = 1'b1;
          tmr_val_s  = LAT_LOAD;
        end else begin
          state_d = START;
        end
      end
      LAT: begin
        if (tmr_exp_s) begin
          state_d = START;
        end else begin
          state_d = LAT;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (pixel_done_in) begin
          if (addr_q == LAST_ADDR) begin
            state_d    = GAP;
            addr_d     = ADDR_ZERO;
            tmr_load_s = 1'b1;
            tmr_val_s  = GAP_LOAD;
          end else begin
            state_d = READ;
            addr_d  = addr_q + ADDR_ONE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      GAP: begin
        if (tmr_exp_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = ADDR_ZERO;
      end
    endcase

    // IDLE always consumes the request; while busy one frame may be queued
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (frame_rdy_in) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    drop_d  = (state_q != IDLE) && frame_rdy_in && pending_q;
    rd_en_d = (state_d == READ);
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    // Timer look-ahead lines the pulse up with the final gap cycle
    done_d  = (state_d == GAP) && tmr_exp_nxt_s;
  end

  // State, address and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      addr_q    <= ADDR_ZERO;
      pending_q <= 1'b0;
      rd_en_q   <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pending_q <= pending_d;
      rd_en_q   <= rd_en_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign rd_en_out       = rd_en_q;
  assign rd_addr_out     = addr_q;
  assign pixel_start_out = start_q;
  assign busy_out        = busy_q;
  assign frame_done_out  = done_q;
  assign frame_drop_out  = drop_q;

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Directed bench for layer_scan_ctl: a cycle table for the first pixels, then
// whole-frame sequences for pending/drop, mid-frame reset, latch gap and a
// second instance with three-cycle RAM latency.
module tb_layer_scan_ctl;

  localparam int PIX = 64;
  localparam int RST = 300;
  localparam int REF = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic frame_rdy;
  logic pixel_done;
  logic sel;

  logic       a_fr, a_pd, a_rd_en, a_start, a_busy, a_done, a_drop;
  logic [5:0] a_addr;
  logic       b_fr, b_pd, b_rd_en, b_start, b_busy, b_done, b_drop;
  logic [5:0] b_addr;

  assign a_fr = frame_rdy & ~sel;
  assign a_pd = pixel_done & ~sel;
  assign b_fr = frame_rdy & sel;
  assign b_pd = pixel_done & sel;

  layer_scan_ctl #(
    .PIXEL_NUM (PIX), .RD_LAT (1), .RST_CYCLES (RST), .REFRESH_CYCLES (REF)
  ) u_dut_a (
    .clk_in (clk), .rst_in (rst), .frame_rdy_in (a_fr), .pixel_done_in (a_pd),
    .rd_en_out (a_rd_en), .rd_addr_out (a_addr), .pixel_start_out (a_start),
    .busy_out (a_busy), .frame_done_out (a_done), .frame_drop_out (a_drop)
  );

  layer_scan_ctl #(
    .PIXEL_NUM (PIX), .RD_LAT (3), .RST_CYCLES (RST), .REFRESH_CYCLES (REF)
  ) u_dut_b (
    .clk_in (clk), .rst_in (rst), .frame_rdy_in (b_fr), .pixel_done_in (b_pd),
    .rd_en_out (b_rd_en), .rd_addr_out (b_addr), .pixel_start_out (b_start),
    .busy_out (b_busy), .frame_done_out (b_done), .frame_drop_out (b_drop)
  );

  logic       rd_en_s, start_s, busy_s, done_s, drop_s;
  logic [5:0] addr_s;
  assign rd_en_s = sel ? b_rd_en : a_rd_en;
  assign start_s = sel ? b_start : a_start;
  assign busy_s  = sel ? b_busy  : a_busy;
  assign done_s  = sel ? b_done  : a_done;
  assign drop_s  = sel ? b_drop  : a_drop;
  assign addr_s  = sel ? b_addr  : a_addr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic fr;
    logic pd;
    logic rd_en;
    logic start;
    logic busy;
    logic done;
    logic drop;
    int   addr;
  } vec_t;

  vec_t tbl[12];

  function automatic int pk(input logic r, input logic s, input logic b,
                            input logic d, input logic dr, input int a);
    logic [5:0] a6;
    a6 = a[5:0];
    return int'({r, s, b, d, dr, a6});
  endfunction

  function automatic int got_now();
    return pk(rd_en_s, start_s, busy_s, done_s, drop_s, int'(addr_s));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs for one rising edge, return at the following falling edge
  task automatic step(input logic fr, input logic pd);
    frame_rdy  = fr;
    pixel_done = pd;
    @(posedge clk);
    @(negedge clk);
    frame_rdy  = 1'b0;
    pixel_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Walks a frame from the first visible rd_en; pixel_done 10 cycles after each start.
  // frame_rdy is injected while at pixels rdy_a / rdy_b; stop_at leaves the DUT in WAIT.
  task automatic run_frame(input string tag, input int lat, input int rdy_a,
                           input int rdy_b, input int stop_at);
    int n;
    int k;
    int extra;
    logic frv;
    extra = 0;
    for (int p = 0; p < PIX; p++) begin
      n = 0;
      while (!rd_en_s && n < 40) begin
        step(1'b0, 1'b0);
        if (start_s) extra++;
        n++;
      end
      if (!rd_en_s) begin
        check($sformatf("%s rd_en timeout p%0d", tag, p), 0, 1);
        return;
      end
      check($sformatf("%s read addr p%0d", tag, p), int'(addr_s), p);
      k = 0;
      do begin
        step(1'b0, 1'b0);
        k++;
        if (rd_en_s) extra++;
      end while (!start_s && k < 8);
      check($sformatf("%s rd_en-to-start p%0d", tag, p), k, lat);
      check($sformatf("%s start addr p%0d", tag, p), int'(addr_s), p);
      if (p == stop_at) begin
        step(1'b0, 1'b0);
        return;
      end
      for (int c = 1; c <= 10; c++) begin
        frv = ((p == rdy_a) || (p == rdy_b)) && (c == 3);
        step(frv, c == 10);
        if (c < 10 && (rd_en_s || start_s)) extra++;
        if (frv) check($sformatf("%s drop p%0d", tag, p), int'(drop_s), int'(p == rdy_b));
      end
    end
    // First latch-gap cycle is on view now
    check({tag, " gap entry busy/addr"}, got_now(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    n = 1;
    while (!done_s && n < RST + 20) begin
      step(1'b0, (n % 7) == 3);
      n++;
      if (rd_en_s || start_s || addr_s != 6'd0) extra++;
    end
    check({tag, " gap length"}, n, RST);
    check({tag, " spurious pulses"}, extra, 0);
  endtask

  initial begin
    int bad;
    int n;
    sel        = 1'b0;
    rst        = 1'b1;
    frame_rdy  = 1'b0;
    pixel_done = 1'b0;

    //          fr    pd    rd    st    busy  done  drop  addr
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2};

    do_reset();
    check("reset state", got_now(), 0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].fr, tbl[i].pd);
      check($sformatf("vec%0d", i), got_now(),
            pk(tbl[i].rd_en, tbl[i].start, tbl[i].busy, tbl[i].done, tbl[i].drop, tbl[i].addr));
    end

    // Reset in WAIT at address 37 with a frame queued
    do_reset();
    step(1'b1, 1'b0);
    run_frame("abort", 1, 5, -1, 37);
    check("abort wait addr", got_now(), pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 37));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort reset outputs", got_now(), 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      if (busy_s || rd_en_s) bad++;
    end
    check("pending cleared by reset", bad, 0);
    step(1'b1, 1'b0);
    check("restart at addr 0", got_now(), pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0));

    // Full frame, queued frame at pixel 20, dropped one at pixel 30
    run_frame("frame1", 1, 20, 30, -1);
    step(1'b0, 1'b0);
    check("idle after frame1", got_now(), 0);
    step(1'b0, 1'b0);
    check("queued scan read", got_now(), pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    run_frame("frame2", 1, -1, -1, -1);

`ifdef LAYER_SCAN_REFRESH_EN
    n = 0;
    do begin
      step(1'b0, 1'b0);
      n++;
    end while (!rd_en_s && n < REF + 20);
    check("refresh replay delay", n, REF);
`else
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b0, 1'b0);
      if (busy_s || rd_en_s) bad++;
    end
    check("stays idle without frame", bad, 0);
`endif

    // Three-cycle RAM latency instance
    sel = 1'b1;
    step(1'b0, 1'b0);
    check("lat3 idle", got_now(), 0);
    step(1'b1, 1'b0);
    run_frame("lat3", 3, -1, -1, -1);
    step(1'b0, 1'b0);
    check("lat3 idle after", int'(busy_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
